// File: rtl/led_seq_ctrl.sv
// Command-driven LED sequencer: latches a pattern/mode/period/step-count command and
// advances the active-low LED word once per programmed tick (rotate, bounce, blink, hold).
module led_seq_ctrl #(
  parameter int                WIDTH         = 12,
  parameter int                DIV_W         = 24,
  parameter int                STEP_W        = 8,
  parameter logic [WIDTH-1:0]  RESET_PATTERN = 12'hFFE,
  parameter logic              OFF_LEVEL     = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_mode,
  input  logic [WIDTH-1:0]  cmd_pattern,
  input  logic [DIV_W-1:0]  cmd_period,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic [WIDTH-1:0]  rot,
  output logic              busy,
  output logic              done
);

  localparam int              POS_W   = $clog2(WIDTH);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [2:0] {M_HOLD = 3'd0, M_ROTL = 3'd1, M_ROTR = 3'd2,
                            M_BOUNCE = 3'd3, M_BLINK = 3'd4} mode_t;

  state_t             state;
  logic [2:0]         mode_r;
  logic [WIDTH-1:0]   pattern_r;
  logic [DIV_W-1:0]   period_r;
  logic [DIV_W-1:0]   divider;
  logic [STEP_W-1:0]  steps_r;
  logic [STEP_W-1:0]  cnt;
  logic [POS_W-1:0]   pos;
  logic               dir;    // 0 = moving left (pos increasing)
  logic               phase;  // blink: 1 = pattern shown

  logic               accept;
  logic               tick;
  logic [WIDTH-1:0]   nxt_rot;
  logic [POS_W-1:0]   nxt_pos;
  logic               nxt_dir;
  logic               nxt_phase;

  function automatic logic [WIDTH-1:0] rotl_by(input logic [WIDTH-1:0] p,
                                               input logic [POS_W-1:0] sh);
    logic [2*WIDTH-1:0] dbl;
    dbl = {p, p} << sh;
    return dbl[2*WIDTH-1:WIDTH];
  endfunction

  // Finite runs hold off new commands until the sequence has completed.
  assign cmd_ready = (state == S_IDLE) || ((state == S_RUN) && (steps_r == '0));
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (divider == period_r);

  always_comb begin
    nxt_rot   = rot;
    nxt_pos   = pos;
    nxt_dir   = dir;
    nxt_phase = phase;
    case (mode_r)
      M_ROTL: nxt_rot = {rot[WIDTH-2:0], rot[WIDTH-1]};
      M_ROTR: nxt_rot = {rot[0], rot[WIDTH-1:1]};
      M_BOUNCE: begin
        // The step that lands on an end is taken; the direction flips for the next one.
        if (!dir) begin
          nxt_pos = pos + POS_W'(1);
          if (nxt_pos == POS_MAX) nxt_dir = 1'b1;
        end else begin
          nxt_pos = pos - POS_W'(1);
          if (nxt_pos == '0) nxt_dir = 1'b0;
        end
        nxt_rot = rotl_by(pattern_r, nxt_pos);
      end
      M_BLINK: begin
        nxt_phase = ~phase;
        nxt_rot   = nxt_phase ? pattern_r : {WIDTH{OFF_LEVEL}};
      end
      default: nxt_rot = rot;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      rot       <= RESET_PATTERN;
      busy      <= 1'b0;
      done      <= 1'b0;
      mode_r    <= '0;
      pattern_r <= '0;
      period_r  <= '0;
      steps_r   <= '0;
      divider   <= '0;
      cnt       <= '0;
      pos       <= '0;
      dir       <= 1'b0;
      phase     <= 1'b1;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // A replacing command wins over a coincident tick and never pulses done.
        state     <= S_RUN;
        busy      <= 1'b1;
        mode_r    <= cmd_mode;
        pattern_r <= cmd_pattern;
        period_r  <= cmd_period;
        steps_r   <= cmd_steps;
        rot       <= cmd_pattern;
        divider   <= '0;
        cnt       <= cmd_steps;
        pos       <= '0;
        dir       <= 1'b0;
        phase     <= 1'b1;
      end else begin
        case (state)
          S_RUN: begin
            if (tick) begin
              divider <= '0;
              rot     <= nxt_rot;
              pos     <= nxt_pos;
              dir     <= nxt_dir;
              phase   <= nxt_phase;
              if (steps_r != '0) begin
                if (cnt != '0) cnt <= cnt - STEP_W'(1);
                if (cnt == STEP_W'(1)) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
            end else begin
              divider <= divider + DIV_W'(1);
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomized bench for led_seq_ctrl: a timeline model derives the expected LED word from
// elapsed clocks since the last accepted command.
module tb_led_seq_ctrl;

  localparam int W = 12;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_mode;
  logic [11:0] cmd_pattern;
  logic [23:0] cmd_period;
  logic [7:0]  cmd_steps;
  logic [11:0] rot;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: last accepted command and clocks elapsed since it
  bit          have_cmd = 1'b0;
  int          m_mode;
  logic [11:0] m_pat;
  longint      m_per;
  longint      m_steps;
  longint      e;

  always #5 clk = ~clk;

  led_seq_ctrl dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_pattern(cmd_pattern), .cmd_period(cmd_period),
    .cmd_steps(cmd_steps), .rot(rot), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [11:0] rotl_n(input logic [11:0] p, input int n);
    logic [11:0] r;
    r = p;
    for (int i = 0; i < n % W; i++) r = {r[10:0], r[11]};
    return r;
  endfunction

  function automatic longint total_clks();
    return m_steps * (m_per + 1);
  endfunction

  function automatic logic [11:0] exp_rot();
    longint k, m;
    if (!have_cmd) return 12'hFFE;
    k = e / (m_per + 1);
    if (m_steps != 0 && k > m_steps) k = m_steps;
    case (m_mode)
      1: return rotl_n(m_pat, int'(k % W));
      2: return rotl_n(m_pat, W - int'(k % W));
      3: begin
        m = k % (2 * (W - 1));
        return rotl_n(m_pat, int'((m <= W - 1) ? m : 2 * (W - 1) - m));
      end
      4: return (k % 2 == 1) ? 12'hFFF : m_pat;
      default: return m_pat;
    endcase
  endfunction

  function automatic bit exp_busy();
    return have_cmd && (m_steps == 0 || e < total_clks());
  endfunction

  function automatic bit exp_done();
    return have_cmd && m_steps != 0 && e == total_clks();
  endfunction

  function automatic bit exp_ready();
    return !have_cmd || m_steps == 0 || e > total_clks();
  endfunction

  // Called at a falling edge: drive inputs, clock once, check at the next falling edge.
  task automatic cycle(input bit v, input logic [2:0] md, input logic [11:0] pat,
                       input logic [23:0] per, input logic [7:0] st);
    bit acc;
    cmd_valid = v; cmd_mode = md; cmd_pattern = pat; cmd_period = per; cmd_steps = st;
    #1;
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready()));
    acc = v && exp_ready();
    @(posedge clk);
    if (acc) begin
      have_cmd = 1'b1; m_mode = int'(md); m_pat = pat;
      m_per = longint'(per); m_steps = longint'(st); e = 0;
    end else if (have_cmd) e++;
    @(negedge clk);
    chk("rot", 32'(rot), 32'(exp_rot()));
    chk("busy", 32'(busy), 32'(exp_busy()));
    chk("done", 32'(done), 32'(exp_done()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'($urandom), 12'($urandom), 24'd0, 8'd0);
  endtask

  task automatic pulse_reset();
    #2 resetn = 1'b0;
    #1;
    have_cmd = 1'b0;
    chk("rst_rot", 32'(rot), 32'(12'hFFE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_pattern = '0;
    cmd_period = '0; cmd_steps = '0;
    repeat (2) @(negedge clk);
    chk("reset_rot", 32'(rot), 32'(12'hFFE));
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    resetn = 1'b1;
    idle(5);

    // finite ROTL, done pulses with the last step
    cycle(1'b1, 3'd1, 12'hFFE, 24'd3, 8'd3);
    idle(16);
    // infinite ROTR replaced by HOLD, then a finite BLINK replaces that
    cycle(1'b1, 3'd2, 12'hFFE, 24'd0, 8'd0);
    idle(6);
    cycle(1'b1, 3'd0, 12'h0F0, 24'd0, 8'd0);
    idle(3);
    cycle(1'b1, 3'd4, 12'h555, 24'd1, 8'd4);
    idle(12);
    // BOUNCE across both ends
    cycle(1'b1, 3'd3, 12'hFFE, 24'd0, 8'd24);
    idle(28);
    // valid held during a finite run, then reset mid-run
    cycle(1'b1, 3'd1, 12'hFFE, 24'd2, 8'd10);
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'd2, 12'h0AA, 24'd0, 8'd0);
    pulse_reset();
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset();
      else if ($urandom_range(0, 11) == 0)
        cycle(1'b1, 3'($urandom_range(0, 7)), 12'($urandom),
              24'($urandom_range(0, 4)),
              ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 30)));
      else idle(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
